// File: rtl/mux16_rr_scheduler.sv
// rtl/mux16_rr_scheduler.sv - round-robin owner sequencer for the shared 16:1 inverting mux
// Optional lock input enabled by defining MUX16_SCHED_LOCK_EN.
module mux16_rr_scheduler #(
    parameter int SEL_W    = 4,
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1<<SEL_W)-1:0]   req,
    input  logic                    rel,
`ifdef MUX16_SCHED_LOCK_EN
    input  logic                    lock,
`endif
    output logic [SEL_W-1:0]        sel,
    output logic                    dis,
    output logic [(1<<SEL_W)-1:0]   gnt,
    output logic                    busy,
    output logic                    tmo
);

    localparam int N = 1 << SEL_W;
    localparam bit TMO_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N-1:0]       gnt_n;
    logic               dis_n;
    logic               busy_n;
    logic               tmo_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   last, last_n;
    logic [SEL_W-1:0]   win;
    logic               win_found;
    logic               lock_act;

`ifdef MUX16_SCHED_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // Search starts just after the previous owner so a held request waits its turn.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand      = '0;
        win       = last;
        win_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = last + SEL_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        dis_n   = dis;
        busy_n  = busy;
        tmo_n   = 1'b0;
        cnt_n   = cnt;
        last_n  = last;
        case (state)
            IDLE: begin
                dis_n  = 1'b1;
                gnt_n  = '0;
                busy_n = 1'b0;
                if (win_found) begin
                    state_n = GRANT;
                    sel_n   = win;
                    gnt_n   = N'(1) << win;
                    dis_n   = 1'b0;
                    busy_n  = 1'b1;
                    last_n  = win;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!lock_act && cnt != {CNT_W{1'b1}}) begin
                    cnt_n = cnt + CNT_W'(1);
                end
                // A voluntary exit wins over a coincident timeout, so tmo stays low then.
                if (rel || !req[sel]) begin
                    state_n = RECOVER;
                    gnt_n   = '0;
                    dis_n   = 1'b1;
                    busy_n  = 1'b0;
                end else if (TMO_EN && !lock_act && cnt == HOLD_LAST) begin
                    state_n = RECOVER;
                    gnt_n   = '0;
                    dis_n   = 1'b1;
                    busy_n  = 1'b0;
                    tmo_n   = 1'b1;
                end
            end
            RECOVER: begin
                state_n = IDLE;
                gnt_n   = '0;
                dis_n   = 1'b1;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                dis_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            dis   <= 1'b1;
            gnt   <= '0;
            busy  <= 1'b0;
            tmo   <= 1'b0;
            cnt   <= '0;
            last  <= {SEL_W{1'b1}};
        end else begin
            state <= state_n;
            sel   <= sel_n;
            dis   <= dis_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            tmo   <= tmo_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// tb/tb_mux16_rr_scheduler.sv - scoreboard bench for mux16_rr_scheduler
module tb_mux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rel = 1'b0;
    logic [15:0] req = '0;
    logic [3:0]  sel;
    logic        dis;
    logic [15:0] gnt;
    logic        busy;
    logic        tmo;
`ifdef MUX16_SCHED_LOCK_EN
    logic        lock = 1'b0;
`endif

    always #5 clk = ~clk;

    mux16_rr_scheduler dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .rel  (rel),
`ifdef MUX16_SCHED_LOCK_EN
        .lock (lock),
`endif
        .sel  (sel),
        .dis  (dis),
        .gnt  (gnt),
        .busy (busy),
        .tmo  (tmo)
    );

    // One entry per ownership: owner, GRANT cycles, tmo in RECOVER, idle cycles before it (-1 = unchecked).
    typedef struct {
        int owner;
        int len;
        int tmo;
        int gap;
    } rec_t;

    rec_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int owner, input int len, input int t, input int gap);
        rec_t r;
        r.owner = owner;
        r.len   = len;
        r.tmo   = t;
        r.gap   = gap;
        exp_q.push_back(r);
    endtask

    int prev_busy = 0;
    int cur_owner = 0;
    int cur_len   = 0;
    int cur_gap   = -1;
    int gap       = -1;
    bit rst_mark  = 1'b1;

    always @(negedge clk) begin
        rec_t e;
        bit   inv;
        inv = (busy == (gnt != 16'h0)) && $onehot0(gnt) && !(tmo && busy);
        if (busy) inv = inv && !dis && (gnt == (16'h1 << sel));
        else      inv = inv && dis;
        chk("invariant", int'(inv), 1);

        if (busy && prev_busy == 0) begin
            cur_owner = int'(sel);
            cur_len   = 1;
            cur_gap   = gap;
            rst_mark  = 1'b0;
        end else if (busy) begin
            cur_len++;
        end else if (prev_busy != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant_owner", cur_owner, -1);
            end else begin
                e = exp_q.pop_front();
                chk("grant_owner", cur_owner, e.owner);
                chk("grant_len", cur_len, e.len);
                chk("recover_tmo", int'(tmo), e.tmo);
                if (e.gap >= 0) chk("handover_gap", cur_gap, e.gap);
            end
            gap = rst_mark ? -1 : 1;
        end else if (gap >= 0) begin
            gap++;
        end
        if (rst) begin
            gap      = -1;
            rst_mark = 1'b1;
        end
        prev_busy = int'(busy);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("reset_sel", int'(sel), 0);
        chk("reset_dis", int'(dis), 1);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tmo", int'(tmo), 0);
        rst = 1'b0;
        tick();

        // Single requester, one-cycle ownership ended by rel.
        push(0, 1, 0, -1);
        req = 16'h0001;
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        req = 16'h0000;
        repeat (3) tick();

        // Rotation 0,5,10,15,0 from a fresh reset, each handover RECOVER+IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(0, 1, 0, -1);
        push(5, 1, 0, 2);
        push(10, 1, 0, 2);
        push(15, 1, 0, 2);
        push(0, 1, 0, 2);
        req = 16'h8421;
        rel = 1'b1;
        repeat (14) tick();
        req = 16'h0000;
        rel = 1'b0;
        repeat (3) tick();

        // Timeout after 8 cycles, then rel coinciding with the timeout edge.
        push(4, 8, 1, -1);
        push(4, 8, 0, 2);
        req = 16'h0010;
        repeat (18) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        req = 16'h0000;
        repeat (3) tick();

        // Reset in the middle of owner 7's grant, then arbitration restarts at 0.
        push(7, 3, 0, -1);
        push(0, 1, 0, -1);
        push(7, 1, 0, 2);
        req = 16'h0080;
        repeat (3) tick();
        rst = 1'b1;
        req = 16'h0081;
        tick();
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_dis", int'(dis), 1);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_tmo", int'(tmo), 0);
        rst = 1'b0;
        tick();
        rel = 1'b1;
        repeat (4) tick();
        req = 16'h0000;
        rel = 1'b0;
        repeat (3) tick();

`ifdef MUX16_SCHED_LOCK_EN
        // Lock freezes the counter at 0 for 20 cycles; timeout follows 8 cycles after release.
        push(4, 27, 1, -1);
        lock = 1'b1;
        req  = 16'h0010;
        repeat (20) tick();
        lock = 1'b0;
        repeat (8) tick();
        req = 16'h0000;
        repeat (3) tick();
`endif

        repeat (2) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Sequences the select and enable lines of the shared 16:1 inverting-output multiplexer datapath.
- Shares that mux among 16 requesters using round-robin arbitration, a bounded hold time and a one-cycle dead time between owners.
- Outputs drive the mux select inputs (4 bits) and its active-high force/disable input directly. Sits between the requester agents and the mux.

Parameters:
- SEL_W, 4, select width; requester count N = 2**SEL_W = 16.
- HOLD_MAX, 8, maximum consecutive GRANT cycles per ownership; 0 disables the timeout.
- CNT_W, 4, hold-counter width; must satisfy HOLD_MAX <= 2**CNT_W - 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; held high while the requester wants the mux.
- rel  input  1  release strobe from the current owner; sampled only in GRANT.
- sel  output SEL_W  mux select, registered.
- dis  output 1  mux force/disable, registered; 1 forces the mux output high (idle).
- gnt  output N  one-hot grant, registered; all zero when no owner.
- busy  output 1  1 while in GRANT.
- tmo  output 1  one-cycle pulse when an ownership is revoked by timeout.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: sel=0, dis=1, gnt=0, busy=0, tmo=0, state=IDLE, hold counter=0, last-grant pointer last=N-1. With last=N-1, requester 0 wins first.
- rst asserted in any state, including mid-GRANT, returns everything to reset values at that edge. There is no dead-time cycle and no tmo pulse.
- States: IDLE, GRANT, RECOVER.
- IDLE:
  - If any req bit is 1 at the edge, the winner is the first set bit searching last+1, last+2, ... modulo N.
  - At that edge: state=GRANT, sel=winner, gnt=onehot(winner), dis=0, busy=1, last=winner, counter=0.
  - Latency is one edge from req sampled to grant visible.
  - If no req bit is set, remain in IDLE.
- GRANT: counter increments each cycle, saturating. At each edge, check in priority order:
  - rst.
  - Normal exit: rel=1 or req[sel]=0 → RECOVER.
  - Timeout: HOLD_MAX!=0 and counter==HOLD_MAX-1 → RECOVER with tmo=1 for the RECOVER cycle.
  - Otherwise stay in GRANT.
  - A normal exit on the same edge as the timeout condition takes precedence: tmo=0.
  - The maximum GRANT duration is HOLD_MAX cycles.
- RECOVER:
  - Exactly one cycle, with dis=1, gnt=0, busy=0; sel holds its last value.
  - Next edge → IDLE. tmo deasserts on that edge.
- Dead time: requests are not evaluated in RECOVER.
  - Minimum handover latency from exit edge to the next grant is 2 edges (RECOVER, then IDLE arbitration).
  - In that IDLE cycle the outputs stay dis=1, gnt=0.
- Fairness: a requester that keeps req high is re-granted only after every other active requester has been served once.
- rel while not in GRANT is ignored. Multiple req changes are tolerated; only sampled values matter.
- Invariants:
  - gnt is zero or one-hot.
  - gnt!=0 implies dis=0 and gnt==onehot(sel).
  - busy==(gnt!=0).

Optional Feature:
- Macro MUX16_SCHED_LOCK_EN.
- When defined: adds input lock (1 bit). While in GRANT with lock=1, the hold counter freezes and the timeout cannot fire. rel and req[sel]=0 still exit normally.
- When undefined: the lock port does not exist, and timeout behaviour is exactly as above.

Test Plan:
- Reset then req=16'h0001 → edge after: sel=0, gnt=16'h0001, dis=0, busy=1; rel pulse → next cycle dis=1, gnt=0 (RECOVER), then IDLE.
- req=16'h8421 held, rel pulsed each grant → grant order 0,5,10,15,0; each handover shows exactly one RECOVER and one IDLE cycle with dis=1.
- HOLD_MAX=8, req=16'h0010 held, no rel → gnt=16'h0010 for exactly 8 cycles, then tmo=1 for 1 cycle with dis=1, then re-grant to 4 after the IDLE cycle.
- In GRANT with counter==HOLD_MAX-1 and rel=1 on the same edge → RECOVER with tmo=0.
- rst asserted mid-GRANT (owner 7) → next cycle sel=0, dis=1, gnt=0, tmo=0; with req=16'h0081 the first grant goes to 0 (last=15).
- With MUX16_SCHED_LOCK_EN, HOLD_MAX=4, lock=1 → owner is held for 20 cycles with no tmo; lock=0 → tmo fires 4 GRANT cycles later (counter was frozen at its pre-lock value, 0 if lock was high from grant).
